// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard signals shared between the datapath and hazard_ctrl.
// master = pipeline datapath, slave = hazard controller.
interface hazard_ctrl_if;
  logic       MemRead_EX;
  logic [4:0] wrin_EX;
  logic [4:0] Rs1_ID;
  logic [4:0] Rs2_ID;
  logic       uses_rs1_ID;
  logic       uses_rs2_ID;
  logic       branch_taken_EX;
  logic       dmem_req;
  logic       dmem_ready;

  logic       PC_WRITE;
  logic       IFID_WRITE;
  logic       IFID_CLEAR;
  logic       IDEX_CLEAR;
  logic       PIPE_HOLD;

  modport master (
    output MemRead_EX, wrin_EX, Rs1_ID, Rs2_ID, uses_rs1_ID, uses_rs2_ID,
           branch_taken_EX, dmem_req, dmem_ready,
    input  PC_WRITE, IFID_WRITE, IFID_CLEAR, IDEX_CLEAR, PIPE_HOLD
  );

  modport slave (
    input  MemRead_EX, wrin_EX, Rs1_ID, Rs2_ID, uses_rs1_ID, uses_rs2_ID,
           branch_taken_EX, dmem_req, dmem_ready,
    output PC_WRITE, IFID_WRITE, IFID_CLEAR, IDEX_CLEAR, PIPE_HOLD
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory
// freeze with timeout-to-halt, and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RESET_N,
  hazard_ctrl_if.slave     hif,
  input  logic             clr_cnt,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        halt_nxt;
  logic        load_use;
  logic        freeze;
  logic        stall_inc;
  logic        flush_inc;

  assign load_use = hif.MemRead_EX && (hif.wrin_EX != 5'd0) &&
                    ((hif.uses_rs1_ID && (hif.Rs1_ID == hif.wrin_EX)) ||
                     (hif.uses_rs2_ID && (hif.Rs2_ID == hif.wrin_EX)));

  always_comb begin
    freeze = 1'b0;
    case (state)
      RUN:      freeze = hif.dmem_req && !hif.dmem_ready;
      MEM_WAIT: freeze = !hif.dmem_ready;
      default:  freeze = 1'b0;
    endcase
  end

  always_comb begin
    hif.PC_WRITE   = 1'b1;
    hif.IFID_WRITE = 1'b1;
    hif.IFID_CLEAR = 1'b0;
    hif.IDEX_CLEAR = 1'b0;
    hif.PIPE_HOLD  = 1'b0;
    state_nxt      = state;
    wait_nxt       = wait_cnt;
    halt_nxt       = halt;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    if (state == ERROR) begin
      hif.PC_WRITE   = 1'b0;
      hif.IFID_WRITE = 1'b0;
      hif.PIPE_HOLD  = 1'b1;
    end else if (freeze) begin
      hif.PC_WRITE   = 1'b0;
      hif.IFID_WRITE = 1'b0;
      hif.PIPE_HOLD  = 1'b1;
      stall_inc      = 1'b1;
      if (state == RUN) begin
        state_nxt = MEM_WAIT;
        wait_nxt  = 16'd1;
      end else if (wait_cnt == TIMEOUT) begin
        state_nxt = ERROR;
        halt_nxt  = 1'b1;
      end else begin
        wait_nxt = wait_cnt + 16'd1;
      end
    end else begin
      // Advance cycle: leaving MEM_WAIT still applies the normal hazard priority.
      state_nxt = RUN;
      wait_nxt  = 16'd0;
      if (hif.branch_taken_EX) begin
        hif.IFID_CLEAR = 1'b1;
        hif.IDEX_CLEAR = 1'b1;
        flush_inc      = 1'b1;
      end else if (load_use) begin
        hif.PC_WRITE   = 1'b0;
        hif.IFID_WRITE = 1'b0;
        hif.IDEX_CLEAR = 1'b1;
        stall_inc      = 1'b1;
      end
    end

    if (!RESET_N) begin
      hif.PC_WRITE   = 1'b0;
      hif.IFID_WRITE = 1'b0;
      hif.IFID_CLEAR = 1'b1;
      hif.IDEX_CLEAR = 1'b1;
      hif.PIPE_HOLD  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= RUN;
      wait_cnt <= '0;
      halt     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      halt     <= halt_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != ERROR) begin
      if (clr_cnt) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_inc && (stall_cnt != '1))
          stall_cnt <= stall_cnt + CNT_W'(1);
        if (flush_inc && (flush_cnt != '1))
          flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the performance counters.
REQ-002 Parameter MEM_TIMEOUT, default 255, sets the maximum number of frozen cycles before ERROR; legal range 1 to 2^16-1.
REQ-003 CLK  in  1  the single clock; all state updates SHALL occur on its rising edge.
REQ-004 RESET_N  in  1  synchronous, active-low reset, sampled on rising CLK.
REQ-005 MemRead_EX  in  1  the instruction in EX is a load.
REQ-006 wrin_EX  in  5  destination register of the EX instruction.
REQ-007 Rs1_ID, Rs2_ID  in  5 each  source registers of the ID instruction.
REQ-008 uses_rs1_ID, uses_rs2_ID  in  1 each  the ID instruction reads Rs1 or Rs2.
REQ-009 branch_taken_EX  in  1  a taken branch or jump is resolved in EX.
REQ-010 dmem_req, dmem_ready  in  1 each  MEM-stage access request and data-memory ready.
REQ-011 clr_cnt  in  1  synchronous clear of the performance counters.
REQ-012 PC_WRITE, IFID_WRITE  out  1 each  update enables for the PC and IF/ID.
REQ-013 IFID_CLEAR, IDEX_CLEAR  out  1 each  bubble insertion into IF/ID and ID/EX (ID/EX uses its CLEAR input).
REQ-014 PIPE_HOLD  out  1  hold for ID/EX, EX/MEM and MEM/WB.
REQ-015 halt  out  1  sticky memory-timeout error.
REQ-016 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-017 States SHALL be RUN, MEM_WAIT and ERROR; control outputs are combinational from the state and inputs, and the counters, halt and wait_cnt (16 bits, internal) are registered.
REQ-018 load_use SHALL be MemRead_EX & (wrin_EX!=0) & ((uses_rs1_ID & Rs1_ID==wrin_EX) | (uses_rs2_ID & Rs2_ID==wrin_EX)).
REQ-019 A freeze cycle is any cycle in RUN with dmem_req & !dmem_ready, or any cycle in MEM_WAIT with !dmem_ready.
REQ-020 In a freeze cycle, outputs SHALL be: PC_WRITE=0, IFID_WRITE=0, IFID_CLEAR=0, IDEX_CLEAR=0, PIPE_HOLD=1.
REQ-021 A non-freeze cycle in RUN or MEM_WAIT is an advance cycle; it SHALL apply the following priority, highest first.
REQ-022 Priority 1, branch_taken_EX: PC_WRITE=1, IFID_WRITE=1, IFID_CLEAR=1, IDEX_CLEAR=1, PIPE_HOLD=0; load_use is ignored.
REQ-023 Priority 2, load_use: PC_WRITE=0, IFID_WRITE=0, IFID_CLEAR=0, IDEX_CLEAR=1, PIPE_HOLD=0 (one bubble per cycle that load_use holds).
REQ-024 Otherwise: PC_WRITE=1, IFID_WRITE=1, both clears 0, PIPE_HOLD=0.
REQ-025 RUN transitions: freeze cycle -> MEM_WAIT with wait_cnt=1; otherwise RUN.
REQ-026 MEM_WAIT, freeze cycle: if wait_cnt==MEM_TIMEOUT -> ERROR and halt=1; else wait_cnt+1 and stay in MEM_WAIT.
REQ-027 MEM_WAIT, advance cycle: -> RUN and wait_cnt=0; the same cycle SHALL apply REQ-022 to REQ-024.
REQ-028 If MEM_TIMEOUT=1, the first MEM_WAIT freeze cycle SHALL enter ERROR.
REQ-029 A taken branch arriving during a freeze SHALL be held by the frozen pipeline and flushed on the first advance cycle.
REQ-030 ERROR SHALL drive the REQ-020 outputs, keep halt=1 and ignore all inputs except RESET_N; it is left only by reset.
REQ-031 stall_cnt SHALL increment in every freeze cycle and every priority-2 cycle; flush_cnt SHALL increment in every priority-1 cycle.
REQ-032 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-033 clr_cnt SHALL zero both counters and SHALL take priority over an increment in the same cycle.
REQ-034 Counters SHALL NOT change in ERROR.

Reset
REQ-035 On rising CLK with RESET_N=0, the block SHALL load state=RUN, wait_cnt=0, halt=0, stall_cnt=0 and flush_cnt=0, from any state including mid-MEM_WAIT or ERROR.
REQ-036 While RESET_N=0, outputs SHALL be PC_WRITE=0, IFID_WRITE=0, IFID_CLEAR=1, IDEX_CLEAR=1, PIPE_HOLD=0.

Verification
REQ-037 Load-use: MemRead_EX=1, wrin_EX=5, Rs2_ID=5, uses_rs2_ID=1 for one cycle -> IDEX_CLEAR=1, PC_WRITE=0, IFID_WRITE=0, stall_cnt=1; the same stimulus with wrin_EX=0 -> no stall.
REQ-038 Branch with load-use: branch_taken_EX=1 together with a load_use match -> both clears=1, PC_WRITE=1, flush_cnt=1, stall_cnt=0.
REQ-039 Memory wait: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 -> freeze for 3 cycles, normal outputs on cycle 4, state=RUN, stall_cnt=3.
REQ-040 Timeout: MEM_TIMEOUT=4, dmem_ready held at 0 -> 5 freeze cycles, then halt=1; a later RESET_N=0 pulse -> halt=0, state=RUN.
REQ-041 Counter boundaries: CNT_W=2 with 5 load-use cycles -> stall_cnt saturates at 3; clr_cnt asserted in a stall cycle -> stall_cnt=0.
REQ-042 Reset during MEM_WAIT: RESET_N=0 at wait_cnt=2 -> next cycle state=RUN, wait_cnt=0, counters=0.
